fractionned_divider: RTL and testbench

//  Iterative 32-bit integer divider: the inverse of fractionned_multiplier, same operand/handshake style.

---
 rtl/fractionned_divider_pkg.sv | 23 ++
 rtl/fractionned_divider_step.sv | 29 ++
 rtl/fractionned_divider.sv | 125 ++++++++++++
 tb/tb_fractionned_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fractionned_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
`default_nettype none

package frac_div_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } div_state_e;

    function automatic logic [DEF_WIDTH-1:0] abs_val(input logic [DEF_WIDTH-1:0] value,
                                                     input logic                 is_signed);
        return (is_signed && value[DEF_WIDTH-1]) ? (~value + 1'b1) : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fractionned_divider_step.sv
// One combinational restoring-division step on a {remainder, quotient} shift pair.
`default_nettype none

module frac_div_step
    import frac_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub_low;
    logic             ge;

    // Comparison needs the extra bit; the difference always fits WIDTH bits when taken.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, divisor_i});
    assign sub_low = shifted[WIDTH-1:0] - divisor_i;
    assign rem_o   = ge ? sub_low : shifted[WIDTH-1:0];
    assign quo_o   = {quo_i[WIDTH-2:0], ge};

endmodule

`default_nettype wire

// File: rtl/fractionned_divider.sv
// Iterative signed/unsigned integer divider, STEPS_PER_CYCLE restoring steps per clock.
`default_nettype none

module fractionned_divider
    import frac_div_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             signed_a,
    input  logic             signed_b,
    input  logic             enable,
    output logic             busy,
    output logic [WIDTH-1:0] output_quotient,
    output logic [WIDTH-1:0] output_remainder,
    output logic             output_valid
);

    localparam logic [CNT_W-1:0] N_ITER  = CNT_W'(WIDTH / STEPS_PER_CYCLE);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             neg_q_q, neg_r_q;

    logic             div_by_zero, overflow, special, neg_a, neg_b;
    logic [WIDTH-1:0] chain_rem [0:STEPS_PER_CYCLE];
    logic [WIDTH-1:0] chain_quo [0:STEPS_PER_CYCLE];

    assign div_by_zero = (input_b == '0);
    assign overflow    = signed_a && signed_b && (input_a == MIN_NEG) && (input_b == '1);
    assign special     = div_by_zero || overflow;
    assign neg_a       = signed_a && input_a[WIDTH-1];
    assign neg_b       = signed_b && input_b[WIDTH-1];

    assign chain_rem[0] = rem_q;
    assign chain_quo[0] = quo_q;

    generate
        for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
            frac_div_step #(.WIDTH(WIDTH)) u_step (
                .rem_i     (chain_rem[gi]),
                .quo_i     (chain_quo[gi]),
                .divisor_i (divisor_q),
                .rem_o     (chain_rem[gi+1]),
                .quo_o     (chain_quo[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = special ? DONE : DIVIDE;
            DIVIDE:  if (count_q == CNT_W'(1)) state_d = FIXUP;
            FIXUP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == DIVIDE) || (state_q == FIXUP);
        output_valid = (state_q == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (enable) begin
                    if (div_by_zero) begin
                        quotient_q  <= '1;
                        remainder_q <= input_a;
                    end else if (overflow) begin
                        quotient_q  <= input_a;
                        remainder_q <= '0;
                    end else begin
                        rem_q     <= '0;
                        quo_q     <= abs_val(input_a, signed_a);
                        divisor_q <= abs_val(input_b, signed_b);
                        neg_q_q   <= neg_a ^ neg_b;
                        neg_r_q   <= neg_a;
                        count_q   <= N_ITER;
                    end
                end
                DIVIDE: begin
                    rem_q   <= chain_rem[STEPS_PER_CYCLE];
                    quo_q   <= chain_quo[STEPS_PER_CYCLE];
                    count_q <= count_q - CNT_W'(1);
                end
                FIXUP: begin
                    quotient_q  <= neg_q_q ? (~quo_q + 1'b1) : quo_q;
                    remainder_q <= neg_r_q ? (~rem_q + 1'b1) : rem_q;
                end
                default: ;
            endcase
        end
    end

    assign output_quotient  = quotient_q;
    assign output_remainder = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_fractionned_divider.sv
// Randomized self-checking bench for fractionned_divider against an arithmetic reference model.
`default_nettype none

module tb_fractionned_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
    logic        sa1 = 1'b0, sb1 = 1'b0, en1 = 1'b0;
    logic        sa4 = 1'b0, sb4 = 1'b0, en4 = 1'b0;
    logic        busy1, valid1, busy4, valid4;
    logic [31:0] q1, r1, q4, r4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fractionned_divider #(.WIDTH(32), .STEPS_PER_CYCLE(1)) dut1 (
        .clock(clk), .reset_n(rst_n), .input_a(a1), .input_b(b1),
        .signed_a(sa1), .signed_b(sb1), .enable(en1), .busy(busy1),
        .output_quotient(q1), .output_remainder(r1), .output_valid(valid1)
    );

    fractionned_divider #(.WIDTH(32), .STEPS_PER_CYCLE(4)) dut4 (
        .clock(clk), .reset_n(rst_n), .input_a(a4), .input_b(b4),
        .signed_a(sa4), .signed_b(sb4), .enable(en4), .busy(busy4),
        .output_quotient(q4), .output_remainder(r4), .output_valid(valid4)
    );

    // Reference: RISC-V style division in 64-bit signed arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sa, input logic sb,
                                  output logic [31:0] q, output logic [31:0] r);
        longint va, vb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            return;
        end
        va = sa ? longint'($signed(a)) : longint'({32'd0, a});
        vb = sb ? longint'($signed(b)) : longint'({32'd0, b});
        lq = va / vb;
        lr = va % vb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b,
                                      input logic sa, input logic sb);
        return (b == 32'd0) || (sa && sb && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Drives one operation into dut1 and measures it; operands are scrambled after start.
    task automatic do_op1(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                          output int edges, output logic [31:0] q, output logic [31:0] r,
                          output bit busy_seen, output bit pulse_ok);
        edges = 0; busy_seen = 0; pulse_ok = 0; q = '0; r = '0;
        @(negedge clk);
        a1 = a; b1 = b; sa1 = sa; sb1 = sb; en1 = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        en1 = 1'b0; a1 = $urandom; b1 = $urandom; sa1 = ~sa; sb1 = ~sb;
        while (!valid1 && edges < 100) begin
            busy_seen |= busy1;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!valid1) begin
            edges = -1;
            return;
        end
        q = q1; r = r1;
        @(posedge clk);
        @(negedge clk);
        pulse_ok = !valid1 && !busy1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy1, valid1, busy4, valid4} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy1=%b valid1=%b busy4=%b valid4=%b expected all 0",
                     busy1, valid1, busy4, valid4);
        end
        checks++;
        if ({q1, r1, q4, r4} !== 128'd0) begin
            errors++;
            $display("FAIL reset_results: got q1=%h r1=%h q4=%h r4=%h expected 0", q1, r1, q4, r4);
        end
        rst_n = 1'b1;
    endtask

    task automatic run_checked(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic sa, input logic sb);
        int edges;
        logic [31:0] q, r, eq, er;
        bit bs, pok, sp;
        model(a, b, sa, sb, eq, er);
        sp = is_special(a, b, sa, sb);
        do_op1(a, b, sa, sb, edges, q, r, bs, pok);
        checks++;
        if (edges !== (sp ? 1 : 34)) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, edges, sp ? 1 : 34);
        end
        if (edges > 0) begin
            checks++;
            if (q !== eq || r !== er) begin
                errors++;
                $display("FAIL %s result: a=%h b=%h sa=%b sb=%b got q=%h r=%h expected q=%h r=%h",
                         name, a, b, sa, sb, q, r, eq, er);
            end
            checks++;
            if (bs !== !sp || !pok) begin
                errors++;
                $display("FAIL %s busy/pulse: got busy_seen=%b pulse_ok=%b expected busy_seen=%b pulse_ok=1",
                         name, bs, pok, !sp);
            end
        end
    endtask

    task automatic test_directed;
        run_checked("unsigned_100_7",  32'd100,        32'd7,          1'b0, 1'b0);
        run_checked("signed_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, 1'b1);
        run_checked("unsigned_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0);
        run_checked("div_zero",        32'd5,          32'd0,          1'b0, 1'b0);
        run_checked("signed_div_zero", 32'hFFFF_FFF0,  32'd0,          1'b1, 1'b1);
        run_checked("overflow_signed", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1);
        run_checked("overflow_unsgn",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0);
        run_checked("mixed_sa",        32'hFFFF_FF9C,  32'hFFFF_FFF0,  1'b1, 1'b0);
        run_checked("mixed_sb",        32'd1000,       32'hFFFF_FFFD,  1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            run_checked("random", a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_abort;
        int pulses = 0;
        @(negedge clk);
        a1 = 32'd100; b1 = 32'd7; sa1 = 1'b0; sb1 = 1'b0; en1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en1 = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, valid1} !== 2'b0 || q1 !== 32'd0 || r1 !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b valid=%b q=%h r=%h expected 0", busy1, valid1, q1, r1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (valid1 || busy1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: got %0d active cycles expected 0", pulses);
        end
        run_checked("after_abort_69_4", 32'd69, 32'd4, 1'b0, 1'b0);
    endtask

    task automatic pick_b2b_operands;
        a4 = $urandom;
        b4 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
        if (b4 == 32'd0 || b4 == 32'hFFFF_FFFF) b4 = 32'd7;
        sa4 = 1'($urandom_range(0, 1));
        sb4 = 1'($urandom_range(0, 1));
    endtask

    // enable held high: a start every 11 edges, each result tied to operands at its start edge.
    task automatic test_back_to_back;
        logic [31:0] ea [0:63];
        logic [31:0] eb [0:63];
        logic        esa [0:63];
        logic        esb [0:63];
        logic [31:0] eq, er;
        bit          exp_v, exp_b;
        @(negedge clk);
        pick_b2b_operands();
        en4 = 1'b1;
        for (int k = 0; k < 55; k++) begin
            @(posedge clk);
            ea[k] = a4; eb[k] = b4; esa[k] = sa4; esb[k] = sb4;
            @(negedge clk);
            exp_v = (k % 11 == 9);
            exp_b = (k % 11 <= 8);
            checks++;
            if (valid4 !== exp_v || busy4 !== exp_b) begin
                errors++;
                $display("FAIL b2b_timing edge %0d: got valid=%b busy=%b expected valid=%b busy=%b",
                         k, valid4, busy4, exp_v, exp_b);
            end
            if (exp_v) begin
                model(ea[k-9], eb[k-9], esa[k-9], esb[k-9], eq, er);
                checks++;
                if (q4 !== eq || r4 !== er) begin
                    errors++;
                    $display("FAIL b2b_result edge %0d: got q=%h r=%h expected q=%h r=%h",
                             k, q4, r4, eq, er);
                end
            end
            pick_b2b_operands();
        end
        en4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
